// File: rtl/hybrid_decode_scheduler_pkg.sv
// Shared constants and FSM state type for the hybrid product-code decode scheduler.
package hybrid_decode_scheduler_pkg;
  localparam int unsigned NCOL      = 15;
  localparam int unsigned NROW      = 4;
  localparam int unsigned COL_CW_W  = 7;
  localparam int unsigned COL_D_W   = 4;
  localparam int unsigned ROW_CW_W  = 15;
  localparam int unsigned ROW_D_W   = 11;
  localparam int unsigned CW_W      = NCOL * COL_CW_W;
  localparam int unsigned DATA_W    = NROW * ROW_D_W;
  localparam int unsigned COL_IDX_W = 4;
  localparam int unsigned ROW_IDX_W = 2;
  localparam int unsigned COL_CNT_W = 4;
  localparam int unsigned ROW_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    ROW  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/hybrid_decode_scheduler_if.sv
// Codeword input / decoded-word output handshake bundle for the decode scheduler.
interface hybrid_decode_scheduler_if;
  import hybrid_decode_scheduler_pkg::*;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [CW_W-1:0]      in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [COL_CNT_W-1:0] out_col_err_cnt;
  logic [ROW_CNT_W-1:0] out_row_err_cnt;
  logic                 busy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_col_err_cnt, out_row_err_cnt, busy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_col_err_cnt, out_row_err_cnt, busy
  );
endinterface

// File: rtl/deinterleaver.sv
// Undo the row interleave: row r bit i (row 0 in the top slice) becomes output bit i*NROW+r.
module deinterleaver #(
  parameter int unsigned NROW    = 4,
  parameter int unsigned ROW_D_W = 11
) (
  input  logic [NROW*ROW_D_W-1:0] data_in,
  output logic [NROW*ROW_D_W-1:0] data_out
);
  // Pure bit permutation.
  always_comb begin
    data_out = '0;
    for (int unsigned r = 0; r < NROW; r++) begin
      for (int unsigned i = 0; i < ROW_D_W; i++) begin
        data_out[i*NROW + r] = data_in[(NROW-1-r)*ROW_D_W + i];
      end
    end
  end
endmodule

// File: rtl/hamming_decoder_15_11.sv
// Single-error-correcting Hamming(15,11) decoder; bit i is code position i+1, parity at 1,2,4,8.
module hamming_decoder_15_11 (
  input  logic [14:0] code_in,
  output logic [10:0] data_out,
  output logic        error_detected
);
  logic [3:0]  syn;
  logic [14:0] fixed;

  // Syndrome, correction, and extraction of the 11 non-parity positions in ascending order.
  always_comb begin
    syn[0] = ^{code_in[0], code_in[2], code_in[4], code_in[6],
               code_in[8], code_in[10], code_in[12], code_in[14]};
    syn[1] = ^{code_in[1], code_in[2], code_in[5], code_in[6],
               code_in[9], code_in[10], code_in[13], code_in[14]};
    syn[2] = ^{code_in[6:3], code_in[14:11]};
    syn[3] = ^code_in[14:7];
    fixed  = code_in;
    for (int unsigned i = 0; i < 15; i++) begin
      if (syn == 4'(i + 1)) fixed[i] = ~code_in[i];
    end
    data_out       = {fixed[14:8], fixed[6:4], fixed[2]};
    error_detected = |syn;
  end
endmodule

// File: rtl/hamming_decoder_7_4.sv
// Single-error-correcting Hamming(7,4) decoder; bit i is code position i+1, parity at 1,2,4.
module hamming_decoder_7_4 (
  input  logic [6:0] code_in,
  output logic [3:0] data_out,
  output logic       error_detected
);
  logic [2:0] syn;
  logic [6:0] fixed;

  // Syndrome names the erroneous position; flip it and extract data positions 3,5,6,7.
  always_comb begin
    syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
    fixed  = code_in;
    for (int unsigned i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1)) fixed[i] = ~code_in[i];
    end
    data_out       = {fixed[6], fixed[5], fixed[4], fixed[2]};
    error_detected = |syn;
  end
endmodule

// File: rtl/hybrid_decode_scheduler_row_buffer.sv
// 4x15 row buffer: written one column (one bit per row) at a time, read one row at a time.
module hds_row_buffer
  import hybrid_decode_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [COL_IDX_W-1:0] wr_col,
  input  logic [COL_D_W-1:0]   wr_bits,
  input  logic [ROW_IDX_W-1:0] rd_row,
  output logic [ROW_CW_W-1:0]  rd_data
);
  logic [ROW_CW_W-1:0] rows_q [NROW];
  logic [ROW_CW_W-1:0] rows_d [NROW];
  logic [3:0]          bit_pos;

  // Column 0 lands in the MSB of each row codeword.
  assign bit_pos = 4'(ROW_CW_W - 1) - wr_col;
  assign rd_data = rows_q[rd_row];

  // Scatter the written column's bits across the rows.
  always_comb begin
    rows_d = rows_q;
    if (wr_en) begin
      for (int unsigned r = 0; r < NROW; r++) begin
        rows_d[r][bit_pos] = wr_bits[r];
      end
    end
  end

  // Row storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rows_q <= '{default: '0};
    else     rows_q <= rows_d;
  end
endmodule

// File: rtl/hybrid_decode_scheduler.sv
// Time-multiplexed product-code decoder: one column decoder over 15 columns, then one
// row decoder over 4 rows, then the deinterleaved word is held on a valid/ready output.
module hybrid_decode_scheduler
  import hybrid_decode_scheduler_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  hybrid_decode_scheduler_if.slave bus
);
  state_e               state_q, state_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  logic [CW_W-1:0]      shadow_q, shadow_d;
  logic [ROW_D_W-1:0]   row_data_q [NROW];
  logic [ROW_D_W-1:0]   row_data_d [NROW];
  logic [COL_CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic                 out_valid_q, out_valid_d;

  logic [6:0]           col_base;
  logic [COL_CW_W-1:0]  col_code;
  logic [COL_D_W-1:0]   col_bits;
  logic                 col_err;
  logic [ROW_CW_W-1:0]  row_code;
  logic [ROW_D_W-1:0]   row_bits;
  logic                 row_err;
  logic                 buf_wr;
  logic [DATA_W-1:0]    out_data_w;

  assign col_base = 7'(col_idx_q) * 7'(COL_CW_W);
  assign col_code = shadow_q[col_base +: COL_CW_W];

  hamming_decoder_7_4 u_col_dec (
    .code_in        (col_code),
    .data_out       (col_bits),
    .error_detected (col_err)
  );

  hds_row_buffer u_row_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_col  (col_idx_q),
    .wr_bits (col_bits),
    .rd_row  (row_idx_q),
    .rd_data (row_code)
  );

  hamming_decoder_15_11 u_row_dec (
    .code_in        (row_code),
    .data_out       (row_bits),
    .error_detected (row_err)
  );

  deinterleaver #(.NROW(NROW), .ROW_D_W(ROW_D_W)) u_deint (
    .data_in  ({row_data_q[0], row_data_q[1], row_data_q[2], row_data_q[3]}),
    .data_out (out_data_w)
  );

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_w;
  assign bus.out_col_err_cnt = col_cnt_q;
  assign bus.out_row_err_cnt = row_cnt_q;

  // Next-state logic; flush outside IDLE abandons the word, flush in IDLE only blocks accept.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    shadow_d    = shadow_q;
    row_data_d  = row_data_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    buf_wr      = 1'b0;
    if (bus.flush) begin
      if (state_q != IDLE) begin
        state_d     = IDLE;
        col_idx_d   = '0;
        row_idx_d   = '0;
        col_cnt_d   = '0;
        row_cnt_d   = '0;
        out_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            shadow_d  = bus.in_data;
            col_cnt_d = '0;
            row_cnt_d = '0;
            col_idx_d = '0;
            state_d   = COL;
          end
        end
        COL: begin
          buf_wr    = 1'b1;
          col_cnt_d = col_cnt_q + COL_CNT_W'(col_err);
          if (col_idx_q == COL_IDX_W'(NCOL - 1)) begin
            row_idx_d = '0;
            state_d   = ROW;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
        ROW: begin
          row_data_d[row_idx_q] = row_bits;
          row_cnt_d             = row_cnt_q + ROW_CNT_W'(row_err);
          if (row_idx_q == ROW_IDX_W'(NROW - 1)) begin
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      shadow_q    <= '0;
      row_data_q  <= '{default: '0};
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      shadow_q    <= shadow_d;
      row_data_q  <= row_data_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_hybrid_decode_scheduler.sv
// Scoreboard bench for hybrid_decode_scheduler: stimulus pushes expectations, a monitor
// pops and compares on each output handshake.
module tb_hybrid_decode_scheduler;
  import hybrid_decode_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hybrid_decode_scheduler_if bus ();

  hybrid_decode_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [43:0] d;
    int          ce;
    int          re;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;
  int   last_hs_cyc = 0;
  int   rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] synd(input logic [14:0] c, input int n);
    logic [3:0] s = '0;
    for (int p = 1; p <= n; p++) if (c[p-1]) s = s ^ 4'(p);
    return s;
  endfunction

  // Product-code encoder: interleave, row-encode (15,11), column-encode (7,4).
  function automatic logic [104:0] encode(input logic [43:0] d);
    logic [104:0] cw = '0;
    logic [14:0]  rc [4];
    logic [6:0]   c;
    logic [3:0]   s;
    int           k;
    for (int r = 0; r < 4; r++) begin
      rc[r] = '0;
      k = 0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & (p - 1)) != 0) begin
          rc[r][p-1] = d[k*4 + r];
          k++;
        end
      end
      s = synd(rc[r], 15);
      rc[r][0] = s[0]; rc[r][1] = s[1]; rc[r][3] = s[2]; rc[r][7] = s[3];
    end
    for (int col = 0; col < 15; col++) begin
      c = '0;
      k = 0;
      for (int p = 1; p <= 7; p++) begin
        if ((p & (p - 1)) != 0) begin
          c[p-1] = rc[k][14-col];
          k++;
        end
      end
      s = synd({8'b0, c}, 7);
      c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
      cw[col*7 +: 7] = c;
    end
    return cw;
  endfunction

  // Golden decoder used for the error counts of arbitrary corrupted words.
  task automatic model(input logic [104:0] cw, output logic [43:0] d, output int ce, output int re);
    logic [14:0] rc [4];
    logic [6:0]  c;
    logic [3:0]  s;
    int          k;
    int          idx;
    ce = 0; re = 0; d = '0;
    for (int r = 0; r < 4; r++) rc[r] = '0;
    for (int col = 0; col < 15; col++) begin
      c = cw[col*7 +: 7];
      s = synd({8'b0, c}, 7);
      if (s != 0) begin ce++; idx = int'(s) - 1; c[idx] = ~c[idx]; end
      k = 0;
      for (int p = 1; p <= 7; p++) begin
        if ((p & (p - 1)) != 0) begin rc[k][14-col] = c[p-1]; k++; end
      end
    end
    for (int r = 0; r < 4; r++) begin
      s = synd(rc[r], 15);
      if (s != 0) begin re++; idx = int'(s) - 1; rc[r][idx] = ~rc[r][idx]; end
      k = 0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & (p - 1)) != 0) begin d[k*4 + r] = rc[r][p-1]; k++; end
      end
    end
  endtask

  // Offer one codeword; returns just after the accepting edge.
  task automatic send(input logic [104:0] cw, input logic [43:0] ed, input int ec,
                      input int er, input bit push);
    bit   ok = 1'b0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = cw;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      acc_cyc = cyc;
      if (push) begin
        e.d = ed; e.ce = ec; e.re = er; e.acc = acc_cyc;
        sbq.push_back(e);
      end
    end
  endtask

  // Monitor: latency on out_valid rise, contents on each output handshake.
  initial begin
    bit   pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.out_valid && !pv) begin
          rise_cyc = cyc;
          chk("unexpected_out_valid", 64'(sbq.size() == 0), 64'd0);
        end
        if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.d));
          chk("col_err_cnt", 64'(bus.out_col_err_cnt), 64'(e.ce));
          chk("row_err_cnt", 64'(bus.out_row_err_cnt), 64'(e.re));
          chk("latency", 64'(rise_cyc - e.acc), 64'd19);
          last_hs_cyc = cyc + 1;
        end
        pv = bus.out_valid;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_out_data"},  64'(bus.out_data), 64'd0);
    chk({tag, "_counts"},    64'({bus.out_col_err_cnt, bus.out_row_err_cnt}), 64'd0);
  endtask

  initial begin
    logic [104:0] ones;
    logic [104:0] walk;
    logic [104:0] cw;
    logic [43:0]  d;
    logic [43:0]  md;
    int           ce, re, nf, b1, b2;
    bit           seen;

    ones = '1;
    walk = '0;
    for (int j = 0; j < 15; j++) walk[j*7] = 1'b1;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Hand-computed directed vectors.
    send(105'h0, 44'h0, 0, 0, 1);
    send(105'h1, 44'h0, 1, 0, 1);
    send(walk, 44'h0, 15, 0, 1);
    send(ones, 44'hFFF_FFFF_FFFF, 0, 0, 1);
    send(ones ^ (105'b1 << 50), 44'hFFF_FFFF_FFFF, 1, 0, 1);
    send(105'h3, 44'h0, 1, 1, 1);   // double flip in col 0 miscorrects into row 0

    // Async reset mid-COL.
    send(ones, 44'h0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midcol_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Backpressure in DONE with a new word waiting.
    bus.out_ready = 1'b0;
    send(ones, 44'hFFF_FFFF_FFFF, 0, 0, 1);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("stall_reach_done", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 105'h1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("stall_out_data", 64'(bus.out_data), 64'hFFF_FFFF_FFFF);
      chk("stall_counts", 64'({bus.out_col_err_cnt, bus.out_row_err_cnt}), 64'd0);
      chk("stall_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(105'h1, 44'h0, 1, 0, 1);
    chk("accept_after_handshake", 64'(acc_cyc - last_hs_cyc), 64'd1);

    // Flush on the second ROW cycle.
    d = 44'h123_4567_89AB;
    send(encode(d), 44'h0, 0, 0, 0);
    repeat (16) @(posedge clk);
    #1;
    chk("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_counts", 64'({bus.out_col_err_cnt, bus.out_row_err_cnt}), 64'd0);
    repeat (25) @(posedge clk);
    #1;
    d = 44'hA5A_5A5A_5A5A;
    send(encode(d), d, 0, 0, 1);

    // Random words with 0-2 bit flips.
    for (int n = 0; n < 2000; n++) begin
      d  = {12'($urandom), $urandom};
      cw = encode(d);
      nf = int'($urandom_range(0, 2));
      b1 = int'($urandom_range(0, 104));
      b2 = (b1 + 1 + int'($urandom_range(0, 103))) % 105;
      if (nf >= 1) cw[b1] = ~cw[b1];
      if (nf == 2) cw[b2] = ~cw[b2];
      model(cw, md, ce, re);
      send(cw, d, ce, re, 1);
    end

    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
